// File: rtl/crc_mem_ctrl_if.sv
// rtl/crc_mem_ctrl_if.sv - request, response, memory and statistics bundle for crc_mem_ctrl
interface crc_mem_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 8
);
  logic                  req0_valid;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [1:0]            rsp_status;
  logic                  mem_wr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  err_detected;
  logic                  err_corrected;
  logic                  busy;
  logic [CNT_W-1:0]      corr_cnt;
  logic [CNT_W-1:0]      uncorr_cnt;
  logic [CNT_W-1:0]      retry_cnt_tot;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
           mem_data_out, err_detected, err_corrected,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_status,
           mem_wr, mem_data_in, busy, corr_cnt, uncorr_cnt, retry_cnt_tot
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
           mem_data_out, err_detected, err_corrected,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_status,
           mem_wr, mem_data_in, busy, corr_cnt, uncorr_cnt, retry_cnt_tot
  );
endinterface

// File: rtl/crc_mem_ctrl.sv
// rtl/crc_mem_ctrl.sv - round-robin write/verify sequencer with retry and saturating error statistics
module crc_mem_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CHK_LAT    = 2,
  parameter int MAX_RETRY  = 2,
  parameter int CNT_W      = 8
) (
  input  logic           clk,
  input  logic           rst,
  crc_mem_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, WRITE, WAIT, CHECK, RESP} state_t;

  localparam int WCW = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;
  localparam logic [WCW-1:0] WAIT_INIT = WCW'((CHK_LAT > 1) ? CHK_LAT - 2 : 0);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  state_t                state;
  logic                  last_grant;
  logic [2:0]            retry;
  logic [WCW-1:0]        wait_cnt;
  logic                  sel;
  logic                  accept;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  uncorrectable;

  // On a tie the requester that did not win last time is selected.
  always_comb begin
    sel            = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    bus.req0_ready = (state == IDLE) && bus.req0_valid && !sel;
    bus.req1_ready = (state == IDLE) && bus.req1_valid && sel;
    accept         = bus.req0_ready || bus.req1_ready;
    acc_data       = sel ? bus.req1_data : bus.req0_data;
    uncorrectable  = bus.err_detected && !bus.err_corrected;
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      last_grant        <= 1'b1;
      retry             <= '0;
      wait_cnt          <= '0;
      bus.mem_wr        <= 1'b0;
      bus.mem_data_in   <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_id        <= 1'b0;
      bus.rsp_data      <= '0;
      bus.rsp_status    <= 2'b00;
      bus.corr_cnt      <= '0;
      bus.uncorr_cnt    <= '0;
      bus.retry_cnt_tot <= '0;
    end else begin
      bus.mem_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bus.mem_data_in <= acc_data;
            bus.rsp_id      <= sel;
            last_grant      <= sel;
            retry           <= '0;
            bus.mem_wr      <= 1'b1;
            state           <= WRITE;
          end
        end
        WRITE: begin
          wait_cnt <= WAIT_INIT;
          state    <= (CHK_LAT == 1) ? CHECK : WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) state <= CHECK;
          else                wait_cnt <= wait_cnt - WCW'(1);
        end
        CHECK: begin
          bus.rsp_data <= bus.mem_data_out;
          if (uncorrectable && (retry < RETRY_MAX)) begin
            retry      <= retry + 3'd1;
            bus.mem_wr <= 1'b1;
            state      <= WRITE;
            if (bus.retry_cnt_tot != '1) bus.retry_cnt_tot <= bus.retry_cnt_tot + CNT_W'(1);
          end else begin
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
            if (uncorrectable) begin
              bus.rsp_status <= 2'b10;
              if (bus.uncorr_cnt != '1) bus.uncorr_cnt <= bus.uncorr_cnt + CNT_W'(1);
            end else if (bus.err_corrected) begin
              bus.rsp_status <= 2'b01;
              if (bus.corr_cnt != '1) bus.corr_cnt <= bus.corr_cnt + CNT_W'(1);
            end else begin
              bus.rsp_status <= 2'b00;
            end
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
